// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: PC input, memory read port, decode handshake, stats.
// master = fetch unit, slave = PC register / memory / decode side.
interface instr_fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STALL_W = 16
) ();
  logic [ADDR_W-1:0]  i_InstrFetch_pc;
  logic               i_InstrFetch_pcValid;
  logic               o_InstrFetch_pcReady;
  logic               o_InstrFetch_memReq;
  logic [ADDR_W-1:0]  o_InstrFetch_memAddr;
  logic               i_InstrFetch_memAck;
  logic [DATA_W-1:0]  i_InstrFetch_memData;
  logic               o_InstrFetch_irValid;
  logic               i_InstrFetch_irReady;
  logic [DATA_W-1:0]  o_InstrFetch_ir;
  logic [ADDR_W-1:0]  o_InstrFetch_irPc;
  logic               i_InstrFetch_flush;
  logic               o_InstrFetch_misalign;
  logic [31:0]        o_InstrFetch_fetchCnt;
  logic [STALL_W-1:0] o_InstrFetch_stallCnt;

  modport master (
    input  i_InstrFetch_pc, i_InstrFetch_pcValid,
    input  i_InstrFetch_memAck, i_InstrFetch_memData,
    input  i_InstrFetch_irReady, i_InstrFetch_flush,
    output o_InstrFetch_pcReady, o_InstrFetch_memReq,
    output o_InstrFetch_memAddr, o_InstrFetch_irValid,
    output o_InstrFetch_ir, o_InstrFetch_irPc,
    output o_InstrFetch_misalign, o_InstrFetch_fetchCnt,
    output o_InstrFetch_stallCnt
  );

  modport slave (
    output i_InstrFetch_pc, i_InstrFetch_pcValid,
    output i_InstrFetch_memAck, i_InstrFetch_memData,
    output i_InstrFetch_irReady, i_InstrFetch_flush,
    input  o_InstrFetch_pcReady, o_InstrFetch_memReq,
    input  o_InstrFetch_memAddr, o_InstrFetch_irValid,
    input  o_InstrFetch_ir, o_InstrFetch_irPc,
    input  o_InstrFetch_misalign, o_InstrFetch_fetchCnt,
    input  o_InstrFetch_stallCnt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding req/ack read, decode handshake, flush.
// Optional IFU_MISALIGN_CHECK_EN turns misaligned PCs into a zero instr.
module instr_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STALL_W = 16
) (
  input  logic          i_InstrFetch_clk,
  input  logic          i_InstrFetch_rstn,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  ir_q, ir_d;
  logic [31:0]        fetch_cnt_q, fetch_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               disc_q, disc_d;
  logic               mem_req_q, ir_valid_q;
  logic               pc_ready, accept;

  assign pc_ready = (state_q == IDLE) |
                    ((state_q == HOLD) &
                     bus.i_InstrFetch_irReady &
                     ~bus.i_InstrFetch_flush);
  assign accept = bus.i_InstrFetch_pcValid & pc_ready;

`ifdef IFU_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic mis_pc;
  assign mis_pc = bus.i_InstrFetch_pc[1:0] != 2'b00;
  assign bus.o_InstrFetch_misalign = mis_q;
`else
  assign bus.o_InstrFetch_misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    disc_d      = disc_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: ;
      REQ: begin
        if (bus.i_InstrFetch_memAck) begin
          disc_d = 1'b0;
          if (disc_q | bus.i_InstrFetch_flush) begin
            state_d = IDLE;
          end else begin
            ir_d    = bus.i_InstrFetch_memData;
            state_d = HOLD;
          end
        end else begin
          // the read cannot be cancelled; remember to drop it
          if (bus.i_InstrFetch_flush) disc_d = 1'b1;
          if (~&stall_cnt_q)
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
      end
      HOLD: begin
        if (bus.i_InstrFetch_flush) begin
          state_d = IDLE;
        end else if (bus.i_InstrFetch_irReady) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      pc_d    = bus.i_InstrFetch_pc;
      state_d = REQ;
    end
`ifdef IFU_MISALIGN_CHECK_EN
    mis_d = mis_q;
    if (accept & mis_pc) begin
      state_d = HOLD;
      ir_d    = '0;
      mis_d   = 1'b1;
    end else if (state_d != HOLD | accept) begin
      mis_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge i_InstrFetch_clk) begin
    if (!i_InstrFetch_rstn) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      disc_q      <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      mem_req_q   <= 1'b0;
      ir_valid_q  <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      disc_q      <= disc_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_req_q   <= (state_d == REQ);
      ir_valid_q  <= (state_d == HOLD);
`ifdef IFU_MISALIGN_CHECK_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign bus.o_InstrFetch_pcReady  = pc_ready;
  assign bus.o_InstrFetch_memReq   = mem_req_q;
  assign bus.o_InstrFetch_memAddr  = {pc_q[ADDR_W-1:2], 2'b00};
  assign bus.o_InstrFetch_irValid  = ir_valid_q;
  assign bus.o_InstrFetch_ir       = ir_q;
  assign bus.o_InstrFetch_irPc     = pc_q;
  assign bus.o_InstrFetch_fetchCnt = fetch_cnt_q;
  assign bus.o_InstrFetch_stallCnt = stall_cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against a transaction model.
// Expected counters and instruction data come from the bench's own bookkeeping.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch_unit dut (
    .i_InstrFetch_clk  (clk),
    .i_InstrFetch_rstn (rstn),
    .bus               (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  longint unsigned exp_fetch = 0;
  longint unsigned exp_stall = 0;

  function automatic longint unsigned sat16(input longint unsigned v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.i_InstrFetch_pc      = '0;
    bus.i_InstrFetch_pcValid = 1'b0;
    bus.i_InstrFetch_memAck  = 1'b0;
    bus.i_InstrFetch_memData = '0;
    bus.i_InstrFetch_irReady = 1'b0;
    bus.i_InstrFetch_flush   = 1'b0;
  endtask

  task automatic issue(input logic [31:0] p);
    bus.i_InstrFetch_pc      = p;
    bus.i_InstrFetch_pcValid = 1'b1;
    #1;
    chk("pcReady_idle", bus.o_InstrFetch_pcReady, 1);
    tick();
    bus.i_InstrFetch_pcValid = 1'b0;
  endtask

  // REQ phase: ad cycles without ack, then ack with data d
  task automatic serve(input logic [31:0] p, input logic [31:0] d,
                       input int ad);
    for (int i = 0; i <= ad; i++) begin
      chk("memReq", bus.o_InstrFetch_memReq, 1);
      chk("memAddr", bus.o_InstrFetch_memAddr, p & 32'hFFFF_FFFC);
      chk("irValid_req", bus.o_InstrFetch_irValid, 0);
      bus.i_InstrFetch_pcValid = 1'($urandom_range(0, 1));
      bus.i_InstrFetch_pc      = $urandom;
      bus.i_InstrFetch_memAck  = (i == ad);
      bus.i_InstrFetch_memData = (i == ad) ? d : $urandom;
      tick();
    end
    bus.i_InstrFetch_memAck  = 1'b0;
    bus.i_InstrFetch_pcValid = 1'b0;
    exp_stall = sat16(exp_stall + longint'(ad));
    chk("irValid_hold", bus.o_InstrFetch_irValid, 1);
    chk("ir", bus.o_InstrFetch_ir, d);
    chk("irPc", bus.o_InstrFetch_irPc, p);
    chk("memReq_hold", bus.o_InstrFetch_memReq, 0);
    chk("stallCnt", bus.o_InstrFetch_stallCnt, exp_stall);
  endtask

  // HOLD phase: rd backpressure cycles, then delivery (optionally next PC)
  task automatic deliver(input logic [31:0] p, input logic [31:0] d,
                         input int rd, input bit nxt,
                         input logic [31:0] np);
    bus.i_InstrFetch_irReady = 1'b0;
    for (int i = 0; i < rd; i++) begin
      bus.i_InstrFetch_pcValid = 1'($urandom_range(0, 1));
      bus.i_InstrFetch_pc      = $urandom;
      #1;
      chk("pcReady_bp", bus.o_InstrFetch_pcReady, 0);
      tick();
      chk("ir_stable", bus.o_InstrFetch_ir, d);
      chk("irPc_stable", bus.o_InstrFetch_irPc, p);
      chk("irValid_bp", bus.o_InstrFetch_irValid, 1);
    end
    bus.i_InstrFetch_irReady = 1'b1;
    bus.i_InstrFetch_pcValid = nxt;
    bus.i_InstrFetch_pc      = np;
    #1;
    chk("pcReady_hold", bus.o_InstrFetch_pcReady, 1);
    tick();
    bus.i_InstrFetch_irReady = 1'b0;
    bus.i_InstrFetch_pcValid = 1'b0;
    exp_fetch = (exp_fetch + 1) % 64'h1_0000_0000;
    chk("fetchCnt", bus.o_InstrFetch_fetchCnt, exp_fetch);
    chk("irValid_done", bus.o_InstrFetch_irValid, 0);
    chk("memReq_next", bus.o_InstrFetch_memReq, nxt);
    if (nxt)
      chk("memAddr_next", bus.o_InstrFetch_memAddr, np & 32'hFFFF_FFFC);
  endtask

  initial begin
    logic [31:0] p, d, np;
    bit pending, nxt;
    quiet();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    chk("rst_memReq", bus.o_InstrFetch_memReq, 0);
    chk("rst_irValid", bus.o_InstrFetch_irValid, 0);
    chk("rst_fetchCnt", bus.o_InstrFetch_fetchCnt, 0);

    // reset in the middle of a fetch, then a late ack
    issue(32'h0000_0080);
    chk("pre_rst_memReq", bus.o_InstrFetch_memReq, 1);
    tick();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    chk("rst2_memReq", bus.o_InstrFetch_memReq, 0);
    chk("rst2_memAddr", bus.o_InstrFetch_memAddr, 0);
    chk("rst2_irValid", bus.o_InstrFetch_irValid, 0);
    chk("rst2_ir", bus.o_InstrFetch_ir, 0);
    chk("rst2_irPc", bus.o_InstrFetch_irPc, 0);
    chk("rst2_misalign", bus.o_InstrFetch_misalign, 0);
    chk("rst2_stallCnt", bus.o_InstrFetch_stallCnt, 0);
    chk("rst2_fetchCnt", bus.o_InstrFetch_fetchCnt, 0);
    bus.i_InstrFetch_memAck  = 1'b1;
    bus.i_InstrFetch_memData = 32'hBAD0_BAD0;
    tick();
    bus.i_InstrFetch_memAck = 1'b0;
    chk("late_ack_irValid", bus.o_InstrFetch_irValid, 0);
    chk("late_ack_memReq", bus.o_InstrFetch_memReq, 0);
    exp_stall = 0;
    exp_fetch = 0;

    // single fetch, ack on third REQ cycle
    issue(32'h0000_0040);
    serve(32'h0000_0040, 32'h2002_0005, 2);
    chk("single_stall2", bus.o_InstrFetch_stallCnt, 2);
    deliver(32'h0000_0040, 32'h2002_0005, 0, 1'b0, 32'h0);
    chk("single_fetch1", bus.o_InstrFetch_fetchCnt, 1);

    // backpressure then back-to-back
    issue(32'h0000_0040);
    serve(32'h0000_0040, 32'h0011_2233, 0);
    deliver(32'h0000_0040, 32'h0011_2233, 4, 1'b1, 32'h0000_0044);
    serve(32'h0000_0044, 32'h4455_6677, 1);
    deliver(32'h0000_0044, 32'h4455_6677, 0, 1'b0, 32'h0);

    // flush in REQ: data dropped once ack arrives
    issue(32'h0000_0100);
    bus.i_InstrFetch_flush = 1'b1;
    tick();
    bus.i_InstrFetch_flush = 1'b0;
    chk("flushReq_memReq1", bus.o_InstrFetch_memReq, 1);
    tick();
    chk("flushReq_memReq2", bus.o_InstrFetch_memReq, 1);
    bus.i_InstrFetch_memAck  = 1'b1;
    bus.i_InstrFetch_memData = 32'hDEAD_BEEF;
    tick();
    bus.i_InstrFetch_memAck = 1'b0;
    exp_stall = sat16(exp_stall + 2);
    chk("flushReq_irValid", bus.o_InstrFetch_irValid, 0);
    chk("flushReq_memReq3", bus.o_InstrFetch_memReq, 0);
    chk("flushReq_stall", bus.o_InstrFetch_stallCnt, exp_stall);
    tick();
    chk("flushReq_irValid2", bus.o_InstrFetch_irValid, 0);
    chk("flushReq_fetch", bus.o_InstrFetch_fetchCnt, exp_fetch);

    // flush in HOLD beats irReady and pcValid
    issue(32'h0000_0200);
    serve(32'h0000_0200, 32'h1234_5678, 1);
    bus.i_InstrFetch_irReady = 1'b1;
    bus.i_InstrFetch_flush   = 1'b1;
    bus.i_InstrFetch_pcValid = 1'b1;
    bus.i_InstrFetch_pc      = 32'h0000_0300;
    #1;
    chk("flushHold_pcReady", bus.o_InstrFetch_pcReady, 0);
    tick();
    quiet();
    chk("flushHold_irValid", bus.o_InstrFetch_irValid, 0);
    chk("flushHold_memReq", bus.o_InstrFetch_memReq, 0);
    chk("flushHold_fetch", bus.o_InstrFetch_fetchCnt, exp_fetch);

    // randomized transactions, some back-to-back
    pending = 1'b0;
    p = 32'h0;
    for (int n = 0; n < 24; n++) begin
      if (!pending) begin
        p = $urandom;
`ifdef IFU_MISALIGN_CHECK_EN
        p[1:0] = 2'b00;
`endif
        issue(p);
      end
      d   = $urandom;
      np  = $urandom;
`ifdef IFU_MISALIGN_CHECK_EN
      np[1:0] = 2'b00;
`endif
      nxt = (n != 23) && ($urandom_range(0, 2) == 0);
      serve(p, d, int'($urandom_range(0, 5)));
      deliver(p, d, int'($urandom_range(0, 3)), nxt, np);
      pending = nxt;
      p = np;
    end

    // misaligned PC
`ifdef IFU_MISALIGN_CHECK_EN
    issue(32'h0000_0042);
    chk("mis_memReq", bus.o_InstrFetch_memReq, 0);
    chk("mis_irValid", bus.o_InstrFetch_irValid, 1);
    chk("mis_ir", bus.o_InstrFetch_ir, 0);
    chk("mis_flag", bus.o_InstrFetch_misalign, 1);
    deliver(32'h0000_0042, 32'h0, 1, 1'b0, 32'h0);
    chk("mis_clear", bus.o_InstrFetch_misalign, 0);
`else
    issue(32'h0000_0042);
    chk("mis_off_addr", bus.o_InstrFetch_memAddr, 32'h0000_0040);
    chk("mis_off_flag", bus.o_InstrFetch_misalign, 0);
    serve(32'h0000_0042, 32'h0A0B_0C0D, 0);
    chk("mis_off_flag2", bus.o_InstrFetch_misalign, 0);
    deliver(32'h0000_0042, 32'h0A0B_0C0D, 0, 1'b0, 32'h0);
`endif

    // stall saturation and fetch counter wrap
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp_stall = 0;
    exp_fetch = 0;
    issue(32'h0000_0400);
    repeat (65534) tick();
    exp_stall = sat16(exp_stall + 65534);
    chk("stall_fffe", bus.o_InstrFetch_stallCnt, exp_stall);
    repeat (3) tick();
    exp_stall = sat16(exp_stall + 3);
    chk("stall_sat", bus.o_InstrFetch_stallCnt, exp_stall);
    bus.i_InstrFetch_memAck  = 1'b1;
    bus.i_InstrFetch_memData = 32'h5555_AAAA;
    tick();
    bus.i_InstrFetch_memAck = 1'b0;
    chk("sat_irValid", bus.o_InstrFetch_irValid, 1);
    chk("sat_hold", bus.o_InstrFetch_stallCnt, 16'hFFFF);
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.fetch_cnt_q;
    exp_fetch = 64'h0_FFFF_FFFF;
    chk("wrap_pre", bus.o_InstrFetch_fetchCnt, exp_fetch);
    deliver(32'h0000_0400, 32'h5555_AAAA, 0, 1'b0, 32'h0);
    chk("wrap_zero", bus.o_InstrFetch_fetchCnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
